// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
// Feeder FSM states, default header byte and minimum start-low time.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    FIRE,
    WAIT_DONE
  } feeder_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         START_LOW_MIN     = 2;

endpackage

// File: rtl/uart_tx_word_feeder_word_fifo.sv
// Synchronous word FIFO with occupancy count for the UART feeder.
// Power-of-two depth; pointers wrap naturally.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_word_feeder.sv
// Word-to-byte feeder driving the UART start/data/ready handshake.
// Define UART_TX_FEEDER_SYNC_EN to prefix each word with a header byte.
module uart_tx_word_feeder
  import uart_pkg::*;
#(
  parameter int         WORD_BYTES       = 4,
  parameter int         FIFO_DEPTH       = 4,
  parameter bit         LSB_FIRST        = 1'b0,
  parameter int         START_LOW_CYCLES = 2,
  parameter logic [7:0] SYNC_BYTE        = SYNC_BYTE_DEFAULT
) (
  input  logic                          uart_clock,
  input  logic                          uart_reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [8*WORD_BYTES-1:0]       in_data,
  output logic                          uart_start,
  output logic [7:0]                    uart_d_in,
  input  logic                          uart_tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int SL = (START_LOW_CYCLES < START_LOW_MIN) ?
                      START_LOW_MIN : START_LOW_CYCLES;
  localparam int LW = $clog2(SL);
`ifdef UART_TX_FEEDER_SYNC_EN
  localparam int NB = WORD_BYTES + 1;
`else
  localparam int NB = WORD_BYTES;
`endif
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  feeder_state_e  state_q, state_d;
  logic [LW-1:0]  low_cnt_q, low_cnt_d;
  logic [BW-1:0]  byte_idx_q, byte_idx_d;
  logic [W-1:0]   word_q, word_d;
  logic [7:0]     byte_q, byte_d;

  logic           fifo_pop;
  logic [W-1:0]   fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;

  word_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (uart_clock),
    .rst   (uart_reset),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  function automatic logic [7:0] pick(
    input logic [W-1:0]  w,
    input logic [BW-1:0] idx
  );
    int i;
    i = int'(idx);
`ifdef UART_TX_FEEDER_SYNC_EN
    if (i == 0) return SYNC_BYTE;
    i = i - 1;
`endif
    if (i >= WORD_BYTES) return 8'h00;
    if (LSB_FIRST) return w[8*i +: 8];
    return w[8*(WORD_BYTES-1-i) +: 8];
  endfunction

  always_comb begin
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    byte_d     = byte_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_d     = fifo_rdata;
          byte_idx_d = '0;
          byte_d     = pick(fifo_rdata, '0);
          low_cnt_d  = '0;
          state_d    = ARM;
        end
      end
      ARM: begin
        if (!uart_tx_ready) begin
          low_cnt_d = '0;
        end else if (low_cnt_q == LW'(SL - 1)) begin
          low_cnt_d = '0;
          state_d   = FIRE;
        end else begin
          low_cnt_d = low_cnt_q + 1'b1;
        end
      end
      // ready still high here is the transmitter's pre-load window
      FIRE: begin
        if (!uart_tx_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (uart_tx_ready) begin
          if (byte_idx_q == BW'(NB - 1)) begin
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            byte_d     = pick(word_q, byte_idx_q + 1'b1);
            low_cnt_d  = '0;
            state_d    = ARM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      state_q    <= IDLE;
      low_cnt_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      byte_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      low_cnt_q  <= low_cnt_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
    end
  end

  assign uart_start = (state_q == FIRE) || (state_q == WAIT_DONE);
  assign busy       = (state_q != IDLE);
  assign uart_d_in  = byte_q;
  assign in_ready   = !fifo_full;

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// Bench for uart_tx_word_feeder: MSB-first and LSB-first instances
// share stimulus, each driving its own transmitter model.
module tb_uart_tx_word_feeder;

  localparam int WB    = 4;
  localparam int FRAME = 6;

  logic        clk = 1'b0;
  logic        uart_reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        stall = 1'b0;

  logic        in_ready   [2];
  logic        uart_start [2];
  logic [7:0]  d_in       [2];
  logic        tx_ready   [2];
  logic [2:0]  fcount     [2];
  logic        busy       [2];

  logic [7:0]  exp_q [2][$];
  int          nfr   [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_word_feeder #(.LSB_FIRST(1'b0)) dut_msb (
    .uart_clock    (clk),
    .uart_reset    (uart_reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready[0]),
    .in_data       (in_data),
    .uart_start    (uart_start[0]),
    .uart_d_in     (d_in[0]),
    .uart_tx_ready (tx_ready[0]),
    .fifo_count    (fcount[0]),
    .busy          (busy[0])
  );

  uart_tx_word_feeder #(.LSB_FIRST(1'b1)) dut_lsb (
    .uart_clock    (clk),
    .uart_reset    (uart_reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready[1]),
    .in_data       (in_data),
    .uart_start    (uart_start[1]),
    .uart_d_in     (d_in[1]),
    .uart_tx_ready (tx_ready[1]),
    .fifo_count    (fcount[1]),
    .busy          (busy[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // transmitter model: edge while idle, ready held 2 more cycles, load, frame
  for (genvar l = 0; l < 2; l++) begin : g_tx
    logic       prev = 1'b0;
    int         ph   = 0;
    int         cnt  = 0;
    logic [7:0] d_edge;
    logic [7:0] e;
    initial begin
      tx_ready[l] = 1'b1;
      nfr[l]      = 0;
    end
    always @(posedge clk) begin
      prev <= uart_start[l];
      if (stall && ph == 0) begin
        tx_ready[l] <= 1'b0;
      end else begin
        case (ph)
          0: begin
            if (tx_ready[l] && uart_start[l] && !prev) begin
              ph     <= 1;
              d_edge <= d_in[l];
            end else begin
              tx_ready[l] <= 1'b1;
            end
          end
          1: ph <= 2;
          2: begin
            chk($sformatf("start_hold%0d", l), uart_start[l], 1);
            chk($sformatf("d_stable%0d", l), d_in[l], d_edge);
            if (exp_q[l].size() == 0) begin
              chk($sformatf("frame_extra%0d", l), 0, 1);
            end else begin
              e = exp_q[l].pop_front();
              chk($sformatf("frame%0d", l), d_in[l], e);
            end
            nfr[l]      <= nfr[l] + 1;
            tx_ready[l] <= 1'b0;
            cnt         <= FRAME;
            ph          <= 3;
          end
          default: begin
            if (cnt == 0) begin
              tx_ready[l] <= 1'b1;
              ph          <= 0;
            end else begin
              cnt <= cnt - 1;
            end
          end
        endcase
      end
    end
  end

  int   low_run   = 0;
  logic gap_armed = 1'b0;

  always @(negedge clk) begin
    if (uart_reset) begin
      gap_armed = 1'b0;
      low_run   = 0;
    end else if (!uart_start[0]) begin
      low_run++;
    end else begin
      if (low_run != 0 && gap_armed) chk("start_gap", low_run >= 2, 1);
      gap_armed = 1'b1;
      low_run   = 0;
    end
  end

  task automatic push_word(input logic [31:0] w, output int waited);
    in_valid = 1'b1;
    in_data  = w;
    waited   = 0;
    while (!in_ready[0] && waited < 2000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 2000) chk("push_timeout", 0, 1);
    @(posedge clk);
`ifdef UART_TX_FEEDER_SYNC_EN
    exp_q[0].push_back(8'hA5);
    exp_q[1].push_back(8'hA5);
`endif
    for (int i = 0; i < WB; i++) begin
      exp_q[0].push_back(w[8*(WB-1-i) +: 8]);
      exp_q[1].push_back(w[8*i +: 8]);
    end
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (n < 3000 && !(exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
           !busy[0] && !busy[1] && tx_ready[0] && tx_ready[1])) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n < 3000, 1);
  endtask

  initial begin
    int w;
    int base;
    uart_reset = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready[0], 1);
    chk("rst_start", uart_start[0], 0);
    chk("rst_d_in", d_in[0], 8'h00);
    chk("rst_count", fcount[0], 0);
    chk("rst_busy", busy[0], 0);
    uart_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single word, latency and byte order
    push_word(32'h12345678, w);
    in_valid = 1'b0;
    chk("push_count", fcount[0], 1);
    @(posedge clk); #1;
    chk("pop_busy", busy[0], 1);
    chk("pop_count", fcount[0], 0);
    chk("first_msb", d_in[0], 8'h12);
    chk("first_lsb", d_in[1], 8'h78);
    chk("lat_k1", uart_start[0], 0);
    @(posedge clk); #1;
    chk("lat_k2", uart_start[0], 0);
    @(posedge clk); #1;
    chk("lat_k3", uart_start[0], 1);
    drain("drain_single");

    // back-to-back words
    push_word(32'hCAFEF00D, w);
    push_word(32'h00FF8001, w);
    in_valid = 1'b0;
    drain("drain_b2b");

    // fill with transmitter stalled
    stall = 1'b1;
    push_word(32'h11111111, w);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_word(32'h22222222, w);
    push_word(32'h33333333, w);
    push_word(32'h44444444, w);
    push_word(32'h55555555, w);
    chk("full_count", fcount[0], 4);
    chk("full_ready", in_ready[0], 0);
    in_data = 32'h66666666;
    repeat (5) @(posedge clk);
    #1;
    chk("held_count", fcount[0], 4);
    stall = 1'b0;
    push_word(32'h66666666, w);
    in_valid = 1'b0;
    chk("fifth_waited", w > 0, 1);
    chk("fifth_count", fcount[0], 4);
    drain("drain_fill");

    // reset while in WAIT_DONE with words queued
    base = nfr[0];
    push_word(32'hA1B2C3D4, w);
    push_word(32'h01020304, w);
    push_word(32'h0A0B0C0D, w);
    in_valid = 1'b0;
    w = 0;
    while (nfr[0] < base + 2 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    chk("two_frames", nfr[0], base + 2);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy[0], 1);
    chk("pre_rst_count", fcount[0], 2);
    uart_reset = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    @(posedge clk); #1;
    uart_reset = 1'b0;
    chk("mid_rst_start", uart_start[0], 0);
    chk("mid_rst_count", fcount[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_start_l", uart_start[1], 0);
    repeat (100) @(posedge clk);
    #1;
    chk("no_frames_msb", nfr[0], base + 2);
    chk("no_frames_lsb", nfr[1], base + 2);
    chk("idle_start", uart_start[0], 0);

    chk("exp_empty0", exp_q[0].size(), 0);
    chk("exp_empty1", exp_q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
